// File: rtl/trade_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trade_pkg : shared widths, trading limits and the order payload type
// Revision  : 1.0
// ---------------------------------------------------------------------------
package trade_pkg;

    localparam int NUM_STOCKS = 4;
    localparam int STOCK_ID_W = 2;
    localparam int PRICE_W    = 14;
    localparam int QTY_W      = 8;
    localparam int CASH_W     = 24;
    localparam int DROP_W     = 8;
    localparam int LOT_QTY    = 10;
    localparam int MAX_POS    = 200;
    localparam int INIT_CASH  = 100000;
    localparam int COOLDOWN   = 4;
    localparam int FIFO_DEPTH = 4;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef struct packed {
        logic                  side;
        logic [STOCK_ID_W-1:0] stock_id;
        logic [PRICE_W-1:0]    price;
        logic [QTY_W-1:0]      qty;
    } order_t;

    localparam int ORDER_W = $bits(order_t);

    // Product is formed at PRICE_W+QTY_W bits, then zero-extended to cash width
    function automatic logic [CASH_W-1:0] lot_cost(input logic [PRICE_W-1:0] price,
                                                   input logic [QTY_W-1:0]   qty);
        logic [PRICE_W+QTY_W-1:0] prod;
        prod = {{QTY_W{1'b0}}, price} * {{PRICE_W{1'b0}}, qty};
        return {{(CASH_W-PRICE_W-QTY_W){1'b0}}, prod};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trade_order_manager_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trade_order_manager_if : signal-in / order-out bundle of the order manager
// Revision               : 1.0
// ---------------------------------------------------------------------------
interface trade_order_manager_if;

    logic                             sig_valid;
    logic                             buy_signal;
    logic                             sell_signal;
    logic [trade_pkg::STOCK_ID_W-1:0] stock_id_in;
    logic [trade_pkg::PRICE_W-1:0]    price_in;

    logic                             order_valid;
    logic                             order_ready;
    logic                             order_side;
    logic [trade_pkg::STOCK_ID_W-1:0] order_stock_id;
    logic [trade_pkg::PRICE_W-1:0]    order_price;
    logic [trade_pkg::QTY_W-1:0]      order_qty;

    logic [trade_pkg::CASH_W-1:0]     cash_balance;
    logic [trade_pkg::DROP_W-1:0]     drop_cnt;

    modport master (
        output sig_valid, buy_signal, sell_signal, stock_id_in, price_in, order_ready,
        input  order_valid, order_side, order_stock_id, order_price, order_qty,
        input  cash_balance, drop_cnt
    );

    modport slave (
        input  sig_valid, buy_signal, sell_signal, stock_id_in, price_in, order_ready,
        output order_valid, order_side, order_stock_id, order_price, order_qty,
        output cash_balance, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/trade_order_manager_order_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// order_fifo : show-ahead FIFO, full judged on the registered count
// Revision   : 1.0
// ---------------------------------------------------------------------------
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         head_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trade_order_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trade_order_manager : applies position/cash/cooldown rules to buy/sell
//                       signals and queues one-lot orders
// Revision            : 1.0
// ---------------------------------------------------------------------------
module trade_order_manager
    import trade_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    trade_order_manager_if.slave  bus
);

    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [QTY_W-1:0]      pos_q  [NUM_STOCKS];
    logic [QTY_W-1:0]      pos_d  [NUM_STOCKS];
    logic [CD_W-1:0]       cool_q [NUM_STOCKS];
    logic [CD_W-1:0]       cool_d [NUM_STOCKS];
    logic [CASH_W-1:0]     cash_q, cash_d;
    logic [DROP_W-1:0]     drop_q, drop_d;

    logic [STOCK_ID_W-1:0] w_id;
    logic [CASH_W-1:0]     w_cost;
    logic [QTY_W:0]        w_pos_after_buy;
    logic [CASH_W:0]       w_cash_plus;
    logic                  w_buy_req;
    logic                  w_sell_req;
    logic                  w_buy_ok;
    logic                  w_sell_ok;
    logic                  w_commit;
    order_t                w_push_order;
    order_t                w_head;
    order_t                w_out;

    logic [ORDER_W-1:0]    w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;

    assign w_id            = bus.stock_id_in;
    assign w_cost          = lot_cost(bus.price_in, QTY_W'(LOT_QTY));
    assign w_pos_after_buy = {1'b0, pos_q[w_id]} + (QTY_W+1)'(LOT_QTY);
    assign w_cash_plus     = {1'b0, cash_q} + {1'b0, w_cost};

    // A simultaneous buy and sell is a conflicting signal and is discarded
    assign w_buy_req  = bus.sig_valid && bus.buy_signal && !bus.sell_signal;
    assign w_sell_req = bus.sig_valid && bus.sell_signal && !bus.buy_signal;

    assign w_buy_ok  = w_buy_req && (cool_q[w_id] == '0)
                       && (w_pos_after_buy <= (QTY_W+1)'(MAX_POS))
                       && (cash_q >= w_cost);
    assign w_sell_ok = w_sell_req && (cool_q[w_id] == '0)
                       && (pos_q[w_id] >= QTY_W'(LOT_QTY));
    assign w_commit  = (w_buy_ok || w_sell_ok) && !w_fifo_full;

    always_comb begin
        w_push_order.side     = w_sell_ok ? SIDE_SELL : SIDE_BUY;
        w_push_order.stock_id = w_id;
        w_push_order.price    = bus.price_in;
        w_push_order.qty      = QTY_W'(LOT_QTY);
    end

    always_comb begin
        for (int i = 0; i < NUM_STOCKS; i++) begin
            pos_d[i]  = pos_q[i];
            cool_d[i] = (cool_q[i] != '0) ? cool_q[i] - CD_W'(1) : cool_q[i];
        end
        cash_d = cash_q;
        drop_d = drop_q;
        if (w_commit) begin
            cool_d[w_id] = CD_W'(COOLDOWN);
            if (w_buy_ok) begin
                pos_d[w_id] = pos_q[w_id] + QTY_W'(LOT_QTY);
                cash_d      = cash_q - w_cost;
            end else begin
                pos_d[w_id] = pos_q[w_id] - QTY_W'(LOT_QTY);
                cash_d      = w_cash_plus[CASH_W] ? '1 : w_cash_plus[CASH_W-1:0];
            end
        end else if (w_buy_ok || w_sell_ok) begin
            drop_d = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                pos_q[i]  <= '0;
                cool_q[i] <= '0;
            end
            cash_q <= CASH_W'(INIT_CASH);
            drop_q <= '0;
        end else begin
            pos_q  <= pos_d;
            cool_q <= cool_d;
            cash_q <= cash_d;
            drop_q <= drop_d;
        end
    end

    order_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ORDER_W)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_commit),
        .push_data (w_push_order),
        .pop       (bus.order_ready),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Payload is forced to zero whenever there is no head entry
    assign w_head = order_t'(w_fifo_head);
    assign w_out  = w_fifo_empty ? '0 : w_head;

    assign bus.order_valid    = (w_fifo_count != '0);
    assign bus.order_side     = w_out.side;
    assign bus.order_stock_id = w_out.stock_id;
    assign bus.order_price    = w_out.price;
    assign bus.order_qty      = w_out.qty;
    assign bus.cash_balance   = cash_q;
    assign bus.drop_cnt       = drop_q;

endmodule
`default_nettype wire
